// File: rtl/ahb_mrmst2mrslv_regslice_if.sv
// rtl/ahb_mrmst2mrslv_regslice_if.sv - AHB link bundle used on both sides of the register slice
interface ahb_mrmst2mrslv_regslice_if #(
   parameter int P_DW = 32
);
   logic [31:0]     haddr;
   logic [1:0]      htrans;
   logic            hwrite;
   logic [2:0]      hsize;
   logic [2:0]      hburst;
   logic [3:0]      hprot;
   logic            hlock;
   logic            hsel;
   logic [P_DW-1:0] hwdata;
   logic [P_DW-1:0] hrdata;
   logic            hready;
   logic            hreadyout;
   logic [1:0]      hresp;

   // Bridge drives the downstream slave through this view
   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hprot, hlock, hsel, hwdata, hready,
      input  hrdata, hreadyout, hresp
   );

   // Bridge answers the upstream master through this view
   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hprot, hlock, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_mrmst2mrslv_regslice.sv
// rtl/ahb_mrmst2mrslv_regslice.sv - AHB address-phase register slice with burst splitting and hang timeout
module ahb_mrmst2mrslv_regslice #(
   parameter int P_DW      = 32,
   parameter int P_TIMEOUT = 0
) (
   input  logic                              clk,
   input  logic                              resetn,
   ahb_mrmst2mrslv_regslice_if.slave         ahb_slv,
   ahb_mrmst2mrslv_regslice_if.master        ahb_mslv,
   output logic                              timeout_pulse
);
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_ERR1, S_ERR2, S_DRAIN
   } state_e;

   state_e      state_q;
   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;
   logic [3:0]  hprot_q;
   logic        hlock_q;
   logic        pend_q;
   logic        tp_q;
   logic        slv_hready;
   logic        capture;
   logic        to_hit;
   logic        unused_inputs;

   assign unused_inputs = ^{ahb_slv.hburst, ahb_slv.htrans[0]};

   always_comb begin
      slv_hready = 1'b0;
      unique case (state_q)
         S_IDLE, S_ERR2: slv_hready = 1'b1;
         S_DATA:         slv_hready = ahb_mslv.hreadyout;
         default:        slv_hready = 1'b0;
      endcase
   end

   assign capture = ahb_slv.htrans[1] & slv_hready;

   assign ahb_slv.hready  = slv_hready;
   assign ahb_slv.hresp   = (state_q == S_DATA) ? ahb_mslv.hresp :
                            ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
   // Read data from any response other than a live DATA phase is discarded
   assign ahb_slv.hrdata  = (state_q == S_DATA) ? ahb_mslv.hrdata : '0;

   assign ahb_mslv.htrans = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign ahb_mslv.haddr  = haddr_q;
   assign ahb_mslv.hwrite = hwrite_q;
   assign ahb_mslv.hsize  = hsize_q;
   assign ahb_mslv.hburst = 3'b000;
   assign ahb_mslv.hprot  = hprot_q;
   assign ahb_mslv.hlock  = hlock_q;
   assign ahb_mslv.hsel   = 1'b1;
   assign ahb_mslv.hready = ((state_q == S_IDLE) || (state_q == S_ADDR)) ? 1'b1 : ahb_mslv.hreadyout;
   assign ahb_mslv.hwdata = ahb_slv.hwdata;
   assign timeout_pulse   = tp_q;

   generate
      if (P_TIMEOUT > 0) begin : g_to
         localparam int CW = $clog2(P_TIMEOUT + 1);
         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               cnt_q <= '0;
            end else if (state_q == S_ADDR) begin
               cnt_q <= '0;
            end else if ((state_q == S_DATA) && !ahb_mslv.hreadyout) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         // True during the P_TIMEOUT-th stalled DATA cycle
         assign to_hit = (cnt_q == CW'(P_TIMEOUT - 1));
      end else begin : g_no_to
         assign to_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         hprot_q  <= '0;
         hlock_q  <= 1'b0;
         pend_q   <= 1'b0;
         tp_q     <= 1'b0;
      end else begin
         tp_q <= 1'b0;
         if (capture) begin
            haddr_q  <= ahb_slv.haddr;
            hwrite_q <= ahb_slv.hwrite;
            hsize_q  <= ahb_slv.hsize;
            hprot_q  <= ahb_slv.hprot;
            hlock_q  <= ahb_slv.hlock;
         end
         unique case (state_q)
            S_IDLE: if (capture) state_q <= S_ADDR;
            S_ADDR: begin
               state_q <= S_DATA;
               pend_q  <= 1'b0;
            end
            S_DATA: begin
               if (ahb_mslv.hreadyout) begin
                  state_q <= capture ? S_ADDR : S_IDLE;
               end else if (to_hit) begin
                  state_q <= S_ERR1;
                  tp_q    <= 1'b1;
               end
            end
            S_ERR1: state_q <= S_ERR2;
            S_ERR2: begin
               if (capture) pend_q <= 1'b1;
               if (ahb_mslv.hreadyout) begin
                  state_q <= capture ? S_ADDR : S_IDLE;
               end else begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: if (ahb_mslv.hreadyout) state_q <= pend_q ? S_ADDR : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
